pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed ID/EX-style stage register.
- Generic pipeline-stage holding register with a valid/ready handshake, a one-entry skid buffer, and synchronous flush/interrupt kill.
- Sits between any two datapath stages (ID/EX, EX/MEM, MEM/WB). Back-pressure propagates through it without a combinational ready path.
- Killed or empty slots always present an all-zero bubble, so a nop reaches downstream logic.

Parameters:
- DATA_W, 32, width of one data field (ir, pc4, rd1, rd2, ext, ...).
- NUM_DATA, 5, number of DATA_W fields carried.
- CTRL_W, 14, width of the packed control bundle (aluop, regdst, memtoreg, epcsel, regwrite, alusrc, memwrite).

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream slot holds a real instruction.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  NUM_DATA*DATA_W  upstream data fields; field k occupies bits [k*DATA_W +: DATA_W].
- flush  in  1  synchronous kill of all held entries (branch/clear).
- hw_int  in  1  synchronous kill, same effect as flush (interrupt entry).
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  main entry control; zero when out_valid=0.
- out_data  out  NUM_DATA*DATA_W  main entry data; zero when out_valid=0.
- occupancy  out  2  number of valid entries (0, 1 or 2).

Behaviour:
- Reset (clr_n=0, asynchronous):
  - main and skid entries cleared to zero, valid bits 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - All state updates happen on the rising clk edge.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- in_ready = !skid_valid, taken from a register. It never depends combinationally on out_ready.
- Kill (flush | hw_int = 1):
  - Next state is EMPTY; both entries zeroed.
  - Any concurrent push is discarded; a concurrent pop still counts as consumed downstream.
  - Kill overrides every other transition.
- EMPTY:
  - push: main <= in, go to ONE.
  - otherwise: stay.
- ONE:
  - push & pop: main <= in, stay ONE.
  - push only: skid <= in, go to FULL.
  - pop only: main zeroed, go to EMPTY.
  - neither: hold.
- FULL:
  - pop: main <= skid, skid zeroed, go to ONE.
  - no pop: hold everything.
  - push is impossible because in_ready=0.
- Ordering is strictly FIFO; the skid entry is never output before the main entry.
- Latency: a push into EMPTY appears on out_* the next cycle.
- Throughput: one entry per cycle when out_ready is held high.
- A zero bubble means ctrl=0 and data=0, which decodes as regwrite=0 and memwrite=0.
- Deassertion of clr_n must not glitch outputs: state stays at the reset values until the first clk edge.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds two output ports, both cleared by clr_n and updated every cycle.
  - stall_cnt (32 bits): increments each cycle with in_valid & !in_ready; saturates at 32'hFFFFFFFF.
  - kill_cnt (16 bits): increments each cycle with flush | hw_int while occupancy != 0; saturates at 16'hFFFF.
- Not defined: both ports and their counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: fill to FULL, pulse clr_n low asynchronously between edges -> out_valid=0, occupancy=0, in_ready=1, out_data=0 immediately.
- Streaming: out_ready=1, push ctrl 14'h0155 / data field0 = 32'h00400000, 32'h00400004, 32'h00400008 on consecutive cycles -> same values on out_data field0 one cycle later each; occupancy stays 1; in_ready stays 1.
- Back-pressure: out_ready=0, push A=32'h11111111 then B=32'h22222222 -> occupancy=2, in_ready=0 on the next cycle. Raise out_ready -> A then B appear in order; in_ready returns to 1 after A pops.
- Kill priority: FULL state, assert hw_int together with in_valid=1 (C=32'h33333333) and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; C is never output.
- Flush on EMPTY and ONE: flush with occupancy 0 -> no change. Flush with occupancy 1 -> out_data=0 next cycle. With PIPE_STAGE_PERF_EN defined, kill_cnt increments only in the second case (0 -> 1).
- Perf saturation (PIPE_STAGE_PERF_EN defined): force stall_cnt to 32'hFFFFFFFE, hold a stall for 3 cycles -> stall_cnt=32'hFFFFFFFF and stays there.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage holding register: valid/ready handshake, one-entry skid buffer,
// synchronous flush/interrupt kill. Optional perf counters under PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 5,
  parameter int CTRL_W   = 14
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic                       flush,
  input  logic                       hw_int,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [15:0]                kill_cnt
`endif
);

  localparam int PAY_W   = NUM_DATA * DATA_W;
  localparam int ENTRY_W = CTRL_W + PAY_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         occ_q, occ_d;

  logic               kill_s;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] in_entry_s;

  assign kill_s     = flush | hw_int;
  assign push_s     = in_valid & in_ready_q;
  assign pop_s      = out_valid_q & out_ready;
  assign in_entry_s = {in_ctrl, in_data};

  // Next-state and entry movement; an empty entry is always held as zero.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (kill_s) begin
      state_d = ST_EMPTY;
      main_d  = {ENTRY_W{1'b0}};
      skid_d  = {ENTRY_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            main_d  = in_entry_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_d = in_entry_s;
          end else if (push_s) begin
            skid_d  = in_entry_s;
            state_d = ST_FULL;
          end else if (pop_s) begin
            main_d  = {ENTRY_W{1'b0}};
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            main_d  = skid_q;
            skid_d  = {ENTRY_W{1'b0}};
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = {ENTRY_W{1'b0}};
          skid_d  = {ENTRY_W{1'b0}};
        end
      endcase
    end
  end

  // Status outputs are precomputed from the next state so they leave flops directly.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    occ_d       = 2'd0;
    case (state_d)
      ST_EMPTY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occ_d       = 2'd0;
      end
      ST_ONE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        occ_d       = 2'd1;
      end
      ST_FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        occ_d       = 2'd2;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occ_d       = 2'd0;
      end
    endcase
  end

  // State, entry and status registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= {ENTRY_W{1'b0}};
      skid_q      <= {ENTRY_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_q[ENTRY_W-1 -: CTRL_W];
  assign out_data  = main_q[PAY_W-1:0];
  assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] kill_cnt_q, kill_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (in_valid && !in_ready_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (kill_s && (occ_q != 2'd0) && (kill_cnt_q != 16'hFFFF)) begin
      kill_cnt_d = kill_cnt_q + 16'd1;
    end else begin
      kill_cnt_d = kill_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cnt_q <= 32'd0;
      kill_cnt_q  <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule
